// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared mode codes, state type and index helper for the arbiter
package arb_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Widest request vector the arbiter family supports
   localparam int MAX_REQ = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // OR-ing the indices of set bits gives the index of a one-hot vector;
   // an all-zero vector maps to 0, which matches the idle owner index.
   function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) begin
            idx = idx | i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection by rotate, priority-find, unrotate
module arb_pick
   import arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   mask,
   input  logic [IDW-1:0] start,
   input  logic           mode,
   output logic [N-1:0]   win,
   output logic [IDW-1:0] win_id,
   output logic           any
);

   logic [N-1:0]   cand;
   logic [N-1:0]   rot;
   logic [N-1:0]   rot_oh;
   logic [IDW-1:0] src;
   int             base;

   // Rotate candidates so the search origin sits at bit 0, isolate the lowest
   // set bit, then rotate the one-hot result back into requester order.
   // Fixed-priority mode is simply a search that always starts at bit 0.
   always_comb begin
      cand   = req & ~mask;
      base   = (mode == MODE_RR) ? int'(start) : 0;
      rot    = '0;
      win    = '0;
      src    = '0;
      for (int i = 0; i < N; i++) begin
         src    = IDW'((i + base) % N);
         rot[i] = cand[src];
      end
      rot_oh = rot & (~rot + N'(1));
      for (int i = 0; i < N; i++) begin
         src      = IDW'((i + base) % N);
         win[src] = rot_oh[i];
      end
      win_id = IDW'(onehot_to_idx(MAX_REQ'(win)));
      any    = |cand;
   end

endmodule

// File: rtl/param_priority_arbiter.sv
// rtl/param_priority_arbiter.sv - N-way arbiter with fixed/round-robin mode, owner lock and hold timeout
module param_priority_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic           mode,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_valid
);

   // Counter wide enough to reach MAX_HOLD; a single bit when timeouts are off
   localparam int HCW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
   localparam int HOLD_SAT  = MAX_HOLD;

   arb_state_t     state, state_nxt;
   logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
   logic [HCW-1:0] hold_cnt, hold_cnt_nxt;
   logic [N-1:0]   gnt_nxt;
   logic [IDW-1:0] gnt_id_nxt;
   logic           gnt_valid_nxt;

   logic           owner_req;
   logic           others_req;
   logic           timeout;
   logic           arbitrate;
   logic [N-1:0]   pick_mask;
   logic [N-1:0]   pick_win;
   logic [IDW-1:0] pick_id;
   logic           pick_any;

   assign owner_req  = |(req & gnt);
   assign others_req = |(req & ~gnt);

   // A hold timeout only forces a handover when someone else is waiting
   assign timeout = (MAX_HOLD > 0) && (state == GRANT) && owner_req && others_req
                    && (hold_cnt == HCW'(HOLD_LAST));

   // New arbitration when idle, when the owner lets go, or on timeout
   assign arbitrate = (state == IDLE) || !owner_req || timeout;

   // On timeout the current owner is excluded from this round only
   assign pick_mask = timeout ? gnt : '0;

   arb_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req    (req),
      .mask   (pick_mask),
      .start  (rr_ptr),
      .mode   (mode),
      .win    (pick_win),
      .win_id (pick_id),
      .any    (pick_any)
   );

   // Next-state and next-output decode; mode only matters on arbitration edges
   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      hold_cnt_nxt  = hold_cnt;
      gnt_nxt       = gnt;
      gnt_id_nxt    = gnt_id;
      gnt_valid_nxt = gnt_valid;
      if (arbitrate) begin
         hold_cnt_nxt = '0;
         if (pick_any) begin
            state_nxt     = GRANT;
            gnt_nxt       = pick_win;
            gnt_id_nxt    = pick_id;
            gnt_valid_nxt = 1'b1;
            // Pointer advances in both modes so a later switch to RR is predictable
            rr_ptr_nxt    = IDW'((int'(pick_id) + 1) % N);
         end else begin
            state_nxt     = IDLE;
            gnt_nxt       = '0;
            gnt_id_nxt    = '0;
            gnt_valid_nxt = 1'b0;
         end
      end else if (hold_cnt != HCW'(HOLD_SAT)) begin
         hold_cnt_nxt = hold_cnt + HCW'(1);
      end
   end

   // State, pointer, hold counter and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         hold_cnt  <= '0;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_ptr_nxt;
         hold_cnt  <= hold_cnt_nxt;
         gnt       <= gnt_nxt;
         gnt_id    <= gnt_id_nxt;
         gnt_valid <= gnt_valid_nxt;
      end
   end

endmodule
